trng_block_scheduler: RTL and testbench
=======================================

// Module: trng_block_scheduler
// PURPOSE
//  Sequences the TRNG datapath: accepts raw entropy bits, runs the Repetition Count Test (RCT),
//  fills the 448-bit message buffer, starts the hash core, then schedules the digest bytes onto UART.
//  ctrl_mode=1 bypasses hashing: raw bits are packed into bytes and sent to UART directly.
//  Sits between the entropy sampler and the buffer/hash/UART blocks inside TRNG.
// PARAMETERS
//  BLOCK_BITS   448  accepted bits per hash message block
//  RCT_CUTOFF   32   consecutive identical bits that declare a health failure (>=2)
//  DIGEST_BYTES 32   hash digest length in bytes
//  CNT_W        9    bit-counter width; must hold BLOCK_BITS
// PORTS
//  TRNG_Clock  in  1      single clock, all logic rising-edge
//  TRNG_Reset  in  1      synchronous, active-high reset
//  trng_en     in  1      run enable; low aborts to IDLE
//  ctrl_mode   in  1      0=hashed, 1=raw; latched only in IDLE and at block boundaries
//  bit_valid   in  1      raw sample strobe from entropy sampler
//  bit_in      in  1      raw sample value
//  buf_wr_en   out 1      write bit_in into message buffer (hashed mode)
//  buf_wr_bit  out 1      bit to write
//  buf_clear   out 1      1-cycle pulse: discard buffer contents
//  hash_start  out 1      1-cycle pulse: hash buffer contents
//  hash_done   in  1      1-cycle pulse from hash core
//  hash_rdy    out 1      digest valid and being drained
//  dig_idx     out 5      digest byte address (dig_byte combinational from it)
//  dig_byte    in  8      digest byte at dig_idx
//  tx_start    out 1      1-cycle pulse: UART sends tx_data
//  tx_data     out 8      byte to transmit, held until tx_busy falls
//  tx_busy     in  1      UART busy
//  failure     out 1      RCT failure flag
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; bit count, run length, dig_idx, byte packer cleared.
//  FSM: IDLE, COLLECT, HASH, DRAIN, TX_WAIT, RAW.
//  IDLE: trng_en=1 -> latch mode_q=ctrl_mode; pulse buf_clear; go COLLECT (mode_q=0) or RAW (mode_q=1).
//  RCT (COLLECT and RAW): on each accepted bit, run=1 if bit differs from last bit or is the first bit,
//   otherwise run+1. When run reaches RCT_CUTOFF:
//   failure<=1 next cycle; COLLECT: buf_clear pulse, bit count=0, run=0, the failing bit is not written;
//   RAW: packer cleared, byte dropped.
//   failure stays high until the next block passes (hash_start issued) or raw byte is sent.
//  COLLECT: bit_valid -> buf_wr_en=1 and buf_wr_bit=bit_in in the same cycle (combinational strobe);
//   count+1. At count==BLOCK_BITS-1 with an accepted bit -> HASH.
//  HASH: hash_start pulse on the entry cycle only; bit_valid ignored; wait hash_done -> DRAIN,
//   dig_idx=0, hash_rdy<=1.
//  DRAIN: when tx_busy=0: tx_data<=dig_byte, tx_start pulse -> TX_WAIT.
//  TX_WAIT: 1 guard cycle, then wait tx_busy=0.
//   If dig_idx<DIGEST_BYTES-1: dig_idx+1 -> DRAIN.
//   Else: hash_rdy<=0, buf_clear pulse, relatch mode_q, -> COLLECT or RAW.
//  RAW: pack bits MSB-first into 8-bit shifter. On the 8th bit: tx_data<=byte, tx_start pulse (tx_busy=0),
//   then TX_WAIT. Bits arriving while a byte is pending are ignored (stall). After the send, return to
//   RAW, relatch mode_q.
//  Latency: accepted bit -> buf_wr_en same cycle; last bit -> hash_start 1 cycle; hash_done -> first tx_start
//   >=1 cycle.
//  trng_en=0 in any non-IDLE state: IDLE next cycle, buf_clear pulse, hash_rdy=0, and failure held.
//   A late hash_done is ignored.
//  hash_done outside HASH is ignored. Simultaneous bit_valid and RCT trip: the trip wins.
//  TRNG_Reset overrides trng_en. Reset mid-DRAIN drops remaining digest bytes; no partial tx_start.
// STRUCTURE
//  Package trng_pkg: state enum, BLOCK_BITS/RCT_CUTOFF/DIGEST_BYTES defaults, UART byte width.
//  Sub-module trng_rct_monitor: last bit, run counter, trip output; cleared by the controller.
//  Top holds the FSM, bit counter, dig_idx, raw byte packer, and tx handshake.
// TESTING
//  1. Hashed, alternating bits x448 -> one hash_start cycle after bit 448.
//     Then hash_done -> 32 tx_start with dig_idx 0..31; failure=0.
//  2. 32 consecutive 1s at bit 100 -> failure=1, buf_clear pulse, count restarts at 0.
//     Next clean 448-bit block -> hash_start, failure=0.
//  3. Raw mode, bits 1,0,1,1,0,0,1,0 -> tx_start with tx_data=8'hB2.
//     Bits during tx_busy are ignored; no buf_wr_en.
//  4. tx_busy held 100 cycles during DRAIN -> dig_idx frozen; no tx_start until busy falls; no byte lost.
//  5. trng_en dropped in HASH, then late hash_done -> IDLE, hash_rdy stays 0, no tx_start.
//  6. TRNG_Reset pulse mid-DRAIN at dig_idx=10 -> all outputs 0 next cycle; restart needs full 448 bits.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared types and default sizing for the TRNG block scheduler and its health monitor.
package trng_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_HASH    = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_TX_WAIT = 3'd4,
    ST_RAW     = 3'd5
  } trng_state_e;

  localparam int unsigned BLOCK_BITS_DEF   = 448;
  localparam int unsigned RCT_CUTOFF_DEF   = 32;
  localparam int unsigned DIGEST_BYTES_DEF = 32;
  localparam int unsigned CNT_W_DEF        = 9;
  localparam int unsigned UART_W           = 8;

endpackage

// File: rtl/trng_rct_monitor.sv
// Repetition Count Test: tracks the run of identical accepted bits and flags a trip
// on the bit that makes the run reach RCT_CUTOFF. A trip restarts the run from zero.
module trng_rct_monitor
  import trng_pkg::*;
#(
  parameter int unsigned RCT_CUTOFF = RCT_CUTOFF_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic bit_valid,
  input  logic bit_in,
  output logic trip
);

  localparam int unsigned RUN_W = $clog2(RCT_CUTOFF + 1);

  logic [RUN_W-1:0] run_q, run_d;
  logic             last_q, last_d;
  logic             repeat_bit;

  // run_q == 0 marks "no previous bit", so the first bit always starts a fresh run
  assign repeat_bit = (run_q != '0) && (bit_in == last_q);
  assign trip       = bit_valid && repeat_bit && (run_q == RUN_W'(RCT_CUTOFF - 1));

  always_comb begin
    run_d  = run_q;
    last_d = last_q;
    if (clear || trip) begin
      run_d  = '0;
      last_d = 1'b0;
    end else if (bit_valid) begin
      last_d = bit_in;
      run_d  = repeat_bit ? run_q + 1'b1 : RUN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_q  <= '0;
      last_q <= 1'b0;
    end else begin
      run_q  <= run_d;
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/trng_block_scheduler.sv
// TRNG datapath sequencer: health-checks raw bits, fills the hash message buffer,
// starts hashing, and streams the digest (or raw packed bytes) to the UART.
module trng_block_scheduler
  import trng_pkg::*;
#(
  parameter int unsigned BLOCK_BITS   = BLOCK_BITS_DEF,
  parameter int unsigned RCT_CUTOFF   = RCT_CUTOFF_DEF,
  parameter int unsigned DIGEST_BYTES = DIGEST_BYTES_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic              TRNG_Clock,
  input  logic              TRNG_Reset,
  input  logic              trng_en,
  input  logic              ctrl_mode,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic              buf_wr_en,
  output logic              buf_wr_bit,
  output logic              buf_clear,
  output logic              hash_start,
  input  logic              hash_done,
  output logic              hash_rdy,
  output logic [4:0]        dig_idx,
  input  logic [7:0]        dig_byte,
  output logic              tx_start,
  output logic [UART_W-1:0] tx_data,
  input  logic              tx_busy,
  output logic              failure
);

  localparam int unsigned PK_W = $clog2(UART_W);

  trng_state_e       state_q, state_d;
  logic              mode_q, mode_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [4:0]        dig_idx_q, dig_idx_d;
  logic [UART_W-2:0] shift_q, shift_d;
  logic [PK_W-1:0]   pk_cnt_q, pk_cnt_d;
  logic [UART_W-1:0] tx_data_q, tx_data_d;
  logic              tx_start_q, tx_start_d;
  logic              hash_start_q, hash_start_d;
  logic              buf_clear_q, buf_clear_d;
  logic              hash_rdy_q, hash_rdy_d;
  logic              failure_q, failure_d;
  logic              guard_q, guard_d;

  logic bit_acc;
  logic rct_trip;
  logic rct_clear;
  logic raw_full;

  // Kept outside the FSM process so the trip path has no combinational loop through it.
  // In RAW the completing bit is only taken when the UART line is free.
  assign raw_full  = (pk_cnt_q == PK_W'(UART_W - 1));
  assign bit_acc   = trng_en && bit_valid &&
                     ((state_q == ST_COLLECT) || ((state_q == ST_RAW) && !(raw_full && tx_busy)));
  assign buf_wr_en  = bit_acc && (state_q == ST_COLLECT) && !rct_trip;
  assign buf_wr_bit = buf_wr_en & bit_in;
  assign rct_clear  = buf_clear_d;

  trng_rct_monitor #(
    .RCT_CUTOFF(RCT_CUTOFF)
  ) u_rct (
    .clk      (TRNG_Clock),
    .rst      (TRNG_Reset),
    .clear    (rct_clear),
    .bit_valid(bit_acc),
    .bit_in   (bit_in),
    .trip     (rct_trip)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    bit_cnt_d    = bit_cnt_q;
    dig_idx_d    = dig_idx_q;
    shift_d      = shift_q;
    pk_cnt_d     = pk_cnt_q;
    tx_data_d    = tx_data_q;
    hash_rdy_d   = hash_rdy_q;
    failure_d    = failure_q;
    guard_d      = guard_q;
    tx_start_d   = 1'b0;
    hash_start_d = 1'b0;
    buf_clear_d  = 1'b0;

    if ((state_q != ST_IDLE) && !trng_en) begin
      state_d     = ST_IDLE;
      buf_clear_d = 1'b1;
      hash_rdy_d  = 1'b0;
      bit_cnt_d   = '0;
      dig_idx_d   = '0;
      shift_d     = '0;
      pk_cnt_d    = '0;
      guard_d     = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (trng_en) begin
            mode_d      = ctrl_mode;
            buf_clear_d = 1'b1;
            bit_cnt_d   = '0;
            shift_d     = '0;
            pk_cnt_d    = '0;
            state_d     = ctrl_mode ? ST_RAW : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (rct_trip) begin
            failure_d   = 1'b1;
            buf_clear_d = 1'b1;
            bit_cnt_d   = '0;
          end else if (bit_acc) begin
            if (bit_cnt_q == CNT_W'(BLOCK_BITS - 1)) begin
              bit_cnt_d    = '0;
              hash_start_d = 1'b1;
              failure_d    = 1'b0;
              state_d      = ST_HASH;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
        ST_HASH: begin
          if (hash_done) begin
            dig_idx_d  = '0;
            hash_rdy_d = 1'b1;
            state_d    = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (!tx_busy) begin
            tx_data_d  = dig_byte;
            tx_start_d = 1'b1;
            guard_d    = 1'b1;
            state_d    = ST_TX_WAIT;
          end
        end
        ST_TX_WAIT: begin
          // guard cycle lets the UART raise tx_busy before it is sampled
          if (guard_q) begin
            guard_d = 1'b0;
          end else if (!tx_busy) begin
            if (!mode_q && (dig_idx_q < 5'(DIGEST_BYTES - 1))) begin
              dig_idx_d = dig_idx_q + 1'b1;
              state_d   = ST_DRAIN;
            end else begin
              if (!mode_q) begin
                hash_rdy_d  = 1'b0;
                buf_clear_d = 1'b1;
                dig_idx_d   = '0;
              end
              mode_d  = ctrl_mode;
              state_d = ctrl_mode ? ST_RAW : ST_COLLECT;
            end
          end
        end
        ST_RAW: begin
          if (rct_trip) begin
            failure_d = 1'b1;
            shift_d   = '0;
            pk_cnt_d  = '0;
          end else if (bit_acc) begin
            if (raw_full) begin
              tx_data_d  = {shift_q, bit_in};
              tx_start_d = 1'b1;
              guard_d    = 1'b1;
              failure_d  = 1'b0;
              shift_d    = '0;
              pk_cnt_d   = '0;
              state_d    = ST_TX_WAIT;
            end else begin
              shift_d  = {shift_q[UART_W-3:0], bit_in};
              pk_cnt_d = pk_cnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge TRNG_Clock) begin
    if (TRNG_Reset) begin
      state_q      <= ST_IDLE;
      mode_q       <= 1'b0;
      bit_cnt_q    <= '0;
      dig_idx_q    <= '0;
      shift_q      <= '0;
      pk_cnt_q     <= '0;
      tx_data_q    <= '0;
      tx_start_q   <= 1'b0;
      hash_start_q <= 1'b0;
      buf_clear_q  <= 1'b0;
      hash_rdy_q   <= 1'b0;
      failure_q    <= 1'b0;
      guard_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      bit_cnt_q    <= bit_cnt_d;
      dig_idx_q    <= dig_idx_d;
      shift_q      <= shift_d;
      pk_cnt_q     <= pk_cnt_d;
      tx_data_q    <= tx_data_d;
      tx_start_q   <= tx_start_d;
      hash_start_q <= hash_start_d;
      buf_clear_q  <= buf_clear_d;
      hash_rdy_q   <= hash_rdy_d;
      failure_q    <= failure_d;
      guard_q      <= guard_d;
    end
  end

  assign buf_clear  = buf_clear_q;
  assign hash_start = hash_start_q;
  assign hash_rdy   = hash_rdy_q;
  assign dig_idx    = dig_idx_q;
  assign tx_start   = tx_start_q;
  assign tx_data    = tx_data_q;
  assign failure    = failure_q;

endmodule

// File: tb/tb_trng_block_scheduler.sv
// Directed bench for trng_block_scheduler with a UART/digest model and a tx byte scoreboard.
module tb_trng_block_scheduler;

  logic       TRNG_Clock = 1'b0;
  logic       TRNG_Reset, trng_en, ctrl_mode, bit_valid, bit_in;
  logic       buf_wr_en, buf_wr_bit, buf_clear, hash_start, hash_done, hash_rdy;
  logic [4:0] dig_idx;
  logic [7:0] dig_byte;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_busy, failure;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         n_wr, n_hs, n_bc, n_tx, busy_cnt;
  logic       last_wr, hold_busy;
  logic [7:0] sb[$];
  logic [7:0] pat;

  always #5 TRNG_Clock = ~TRNG_Clock;

  // digest ROM model: byte i = 7*i + 0x31
  assign dig_byte = 8'(dig_idx) * 8'd7 + 8'h31;

  trng_block_scheduler #(
    .BLOCK_BITS  (448),
    .RCT_CUTOFF  (32),
    .DIGEST_BYTES(32),
    .CNT_W       (9)
  ) dut (
    .TRNG_Clock(TRNG_Clock),
    .TRNG_Reset(TRNG_Reset),
    .trng_en   (trng_en),
    .ctrl_mode (ctrl_mode),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .buf_wr_en (buf_wr_en),
    .buf_wr_bit(buf_wr_bit),
    .buf_clear (buf_clear),
    .hash_start(hash_start),
    .hash_done (hash_done),
    .hash_rdy  (hash_rdy),
    .dig_idx   (dig_idx),
    .dig_byte  (dig_byte),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .failure   (failure)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: observe outputs just after the falling edge, update the UART model, move to next falling edge.
  task automatic cyc();
    logic [7:0] e;
    #1;
    last_wr = buf_wr_en;
    if (buf_wr_en === 1'b1) begin
      n_wr++;
      chk("wr_bit", 32'(buf_wr_bit), 32'(bit_in));
    end
    if (hash_start === 1'b1) n_hs++;
    if (buf_clear === 1'b1) n_bc++;
    if (tx_start === 1'b1) begin
      n_tx++;
      chk("tx_start_while_busy", 32'(tx_busy), 32'd0);
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("tx_data", 32'(tx_data), 32'(e));
      end
      busy_cnt = 4;
    end
    tx_busy = hold_busy || (busy_cnt != 0);
    if (busy_cnt != 0) busy_cnt--;
    @(negedge TRNG_Clock);
  endtask

  task automatic feed_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    cyc();
    bit_valid = 1'b0;
  endtask

  task automatic feed_alt(input int n);
    for (int i = 0; i < n; i++) feed_bit(i[0]);
  endtask

  task automatic push_digest();
    for (int i = 0; i < 32; i++) sb.push_back(8'(i * 7 + 49));
  endtask

  task automatic wait_drained(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (hash_rdy === 1'b0) break;
      cyc();
    end
    chk("drain_done", 32'(hash_rdy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    TRNG_Reset = 1'b1; trng_en = 1'b0; ctrl_mode = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    hash_done = 1'b0; tx_busy = 1'b0; hold_busy = 1'b0; busy_cnt = 0;
    n_wr = 0; n_hs = 0; n_bc = 0; n_tx = 0; last_wr = 1'b0;
    @(negedge TRNG_Clock);
    repeat (3) cyc();
    chk("rst_buf_clear",  32'(buf_clear), 32'd0);
    chk("rst_hash_start", 32'(hash_start), 32'd0);
    chk("rst_hash_rdy",   32'(hash_rdy), 32'd0);
    chk("rst_dig_idx",    32'(dig_idx), 32'd0);
    chk("rst_tx_start",   32'(tx_start), 32'd0);
    chk("rst_tx_data",    32'(tx_data), 32'd0);
    chk("rst_failure",    32'(failure), 32'd0);
    chk("rst_buf_wr_en",  32'(buf_wr_en), 32'd0);
    TRNG_Reset = 1'b0;

    // 1: hashed block of alternating bits, then full digest drain
    trng_en = 1'b1;
    cyc();
    chk("t1_start_clear", 32'(buf_clear), 32'd1);
    n_wr = 0; n_hs = 0; n_tx = 0;
    feed_alt(448);
    chk("t1_hash_start", 32'(hash_start), 32'd1);
    chk("t1_wr_count", 32'(n_wr), 32'd448);
    chk("t1_failure", 32'(failure), 32'd0);
    bit_valid = 1'b1; bit_in = 1'b1;
    repeat (3) cyc();
    bit_valid = 1'b0;
    chk("t1_hash_ignores_bits", 32'(n_wr), 32'd448);
    push_digest();
    hash_done = 1'b1;
    cyc();
    hash_done = 1'b0;
    chk("t1_hash_rdy", 32'(hash_rdy), 32'd1);
    chk("t1_no_immediate_tx", 32'(tx_start), 32'd0);
    wait_drained(600);
    chk("t1_tx_count", 32'(n_tx), 32'd32);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);
    chk("t1_single_hash_start", 32'(n_hs), 32'd1);
    chk("t1_failure_end", 32'(failure), 32'd0);

    // 2: run of 32 ones at bit 100 trips the RCT and restarts the block
    n_wr = 0; n_hs = 0;
    feed_alt(99);
    for (int i = 0; i < 31; i++) feed_bit(1'b1);
    chk("t2_no_fail_before_trip", 32'(failure), 32'd0);
    feed_bit(1'b1);
    chk("t2_trip_bit_not_written", 32'(last_wr), 32'd0);
    chk("t2_failure", 32'(failure), 32'd1);
    chk("t2_buf_clear", 32'(buf_clear), 32'd1);
    chk("t2_wr_count", 32'(n_wr), 32'd130);
    feed_alt(447);
    chk("t2_no_early_hash", 32'(n_hs), 32'd0);
    chk("t2_failure_held", 32'(failure), 32'd1);
    feed_bit(1'b1);
    chk("t2_hash_start", 32'(hash_start), 32'd1);
    chk("t2_failure_cleared", 32'(failure), 32'd0);

    // 4: UART busy held for 100 cycles at the start of the drain
    hold_busy = 1'b1;
    n_tx = 0;
    push_digest();
    hash_done = 1'b1;
    cyc();
    hash_done = 1'b0;
    repeat (100) cyc();
    chk("t4_no_tx_while_busy", 32'(n_tx), 32'd0);
    chk("t4_dig_idx_frozen", 32'(dig_idx), 32'd0);
    chk("t4_hash_rdy_held", 32'(hash_rdy), 32'd1);
    hold_busy = 1'b0;
    wait_drained(600);
    chk("t4_tx_count", 32'(n_tx), 32'd32);
    chk("t4_sb_empty", 32'(sb.size()), 32'd0);

    // 5: enable dropped during HASH, late hash_done ignored
    n_hs = 0; n_tx = 0;
    feed_alt(448);
    chk("t5_hash_start", 32'(hash_start), 32'd1);
    trng_en = 1'b0;
    cyc();
    chk("t5_abort_clear", 32'(buf_clear), 32'd1);
    chk("t5_abort_hash_rdy", 32'(hash_rdy), 32'd0);
    hash_done = 1'b1;
    cyc();
    hash_done = 1'b0;
    repeat (20) cyc();
    chk("t5_no_tx", 32'(n_tx), 32'd0);
    chk("t5_hash_rdy_low", 32'(hash_rdy), 32'd0);
    chk("t5_hash_start_count", 32'(n_hs), 32'd1);

    // 3: raw mode packs MSB-first and ignores bits while a byte is in flight
    n_wr = 0; n_tx = 0;
    ctrl_mode = 1'b1; trng_en = 1'b1;
    cyc();
    sb.push_back(8'hB2);
    pat = 8'hB2;
    for (int i = 7; i >= 0; i--) feed_bit(pat[i]);
    bit_valid = 1'b1; bit_in = 1'b1;
    repeat (4) cyc();
    bit_valid = 1'b0;
    repeat (6) cyc();
    chk("t3_first_byte_sent", 32'(n_tx), 32'd1);
    sb.push_back(8'h5C);
    pat = 8'h5C;
    for (int i = 7; i >= 0; i--) feed_bit(pat[i]);
    repeat (8) cyc();
    chk("t3_second_byte_sent", 32'(n_tx), 32'd2);
    chk("t3_sb_empty", 32'(sb.size()), 32'd0);
    chk("t3_no_buf_writes", 32'(n_wr), 32'd0);
    chk("t3_failure", 32'(failure), 32'd0);

    // 6: reset in the middle of the drain
    trng_en = 1'b0;
    cyc();
    ctrl_mode = 1'b0; trng_en = 1'b1;
    cyc();
    n_hs = 0; n_tx = 0;
    feed_alt(448);
    chk("t6_hash_start", 32'(hash_start), 32'd1);
    push_digest();
    hash_done = 1'b1;
    cyc();
    hash_done = 1'b0;
    for (int k = 0; k < 400; k++) begin
      if (dig_idx === 5'd10) break;
      cyc();
    end
    chk("t6_reached_idx10", 32'(dig_idx), 32'd10);
    TRNG_Reset = 1'b1;
    cyc();
    chk("t6_rst_tx_start",   32'(tx_start), 32'd0);
    chk("t6_rst_tx_data",    32'(tx_data), 32'd0);
    chk("t6_rst_dig_idx",    32'(dig_idx), 32'd0);
    chk("t6_rst_hash_rdy",   32'(hash_rdy), 32'd0);
    chk("t6_rst_buf_clear",  32'(buf_clear), 32'd0);
    chk("t6_rst_hash_start", 32'(hash_start), 32'd0);
    chk("t6_rst_failure",    32'(failure), 32'd0);
    chk("t6_tx_before_reset", 32'(n_tx), 32'd10);
    TRNG_Reset = 1'b0;
    sb.delete();
    n_hs = 0;
    cyc();
    feed_alt(447);
    chk("t6_no_early_hash", 32'(n_hs), 32'd0);
    feed_bit(1'b1);
    chk("t6_hash_after_full_block", 32'(hash_start), 32'd1);

    trng_en = 1'b0;
    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
